// File: rtl/uart_link_ctrl.sv
// simpleuart register-port sequencer: RX colour-command decode, ACK/NAK
// response slot, and round-robin TX sharing with one user requester.
module uart_link_ctrl #(
    parameter bit          BANNER_EN   = 1'b1,
    parameter logic [7:0]  BANNER_CHAR = 8'h50,
    parameter logic [7:0]  ACK_CHAR    = 8'h4B,
    parameter logic [7:0]  NAK_CHAR    = 8'h3F,
    parameter int unsigned TX_TIMEOUT  = 1000
) (
    input  logic        hw_clk,
    input  logic        resetn,
    output logic        uart_we,
    output logic        uart_re,
    output logic [31:0] uart_di,
    input  logic [31:0] uart_do,
    input  logic        uart_wait,
    input  logic        usr_tx_valid,
    input  logic [7:0]  usr_tx_data,
    output logic        usr_tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [2:0]  rgb,
    output logic        tx_err
);

    localparam int CW = $clog2(TX_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TX_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic            r_we, w_we;
    logic            r_re, w_re;
    logic [7:0]      r_di, w_di;
    logic            r_rxv, w_rxv;
    logic [7:0]      r_rxd, w_rxd;
    logic [2:0]      r_rgb, w_rgb;
    logic            r_err, w_err;
    logic            r_rdy, w_rdy;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_slot_v, w_slot_v;
    logic [7:0]      r_slot_d, w_slot_d;
    logic            r_last_usr, w_last_usr;
    logic            r_gnt_usr, w_gnt_usr;

    logic            w_rx_take;
    logic            w_is_digit;
    logic            w_pick_usr;
    logic [CW-1:0]   w_cnt_inc;

    assign w_rx_take  = (uart_do != 32'hFFFF_FFFF) && !r_slot_v;
    assign w_is_digit = (uart_do[7:3] == 5'b00110);
    // last_grant == user hands a tie to the response slot
    assign w_pick_usr = usr_tx_valid && (!r_slot_v || !r_last_usr);
    assign w_cnt_inc  = r_cnt + CW'(1);

    always_comb begin
        w_state    = r_state;
        w_we       = r_we;
        w_re       = 1'b0;
        w_di       = r_di;
        w_rxv      = 1'b0;
        w_rxd      = r_rxd;
        w_rgb      = r_rgb;
        w_err      = r_err;
        w_rdy      = 1'b0;
        w_cnt      = r_cnt;
        w_slot_v   = r_slot_v;
        w_slot_d   = r_slot_d;
        w_last_usr = r_last_usr;
        w_gnt_usr  = r_gnt_usr;
        unique case (r_state)
            S_IDLE: begin
                if (w_rx_take) begin
                    w_state  = S_RD;
                    w_re     = 1'b1;
                    w_rxv    = 1'b1;
                    w_rxd    = uart_do[7:0];
                    w_slot_v = 1'b1;
                    if (w_is_digit) begin
                        w_rgb    = uart_do[2:0];
                        w_slot_d = ACK_CHAR;
                    end else begin
                        w_slot_d = NAK_CHAR;
                    end
                end else if (r_slot_v || usr_tx_valid) begin
                    w_state    = S_WR;
                    w_we       = 1'b1;
                    w_di       = w_pick_usr ? usr_tx_data : r_slot_d;
                    w_last_usr = w_pick_usr;
                    w_gnt_usr  = w_pick_usr;
                    w_cnt      = '0;
                end
            end
            S_RD: begin
                w_state = S_IDLE;
            end
            S_WR: begin
                w_cnt = w_cnt_inc;
                if (!uart_wait || (w_cnt_inc == TO_VAL)) begin
                    w_state = S_DONE;
                    w_we    = 1'b0;
                    if (uart_wait)
                        w_err = 1'b1;
                    if (r_gnt_usr)
                        w_rdy = 1'b1;
                    else
                        w_slot_v = 1'b0;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_we    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hw_clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_di       <= 8'h00;
            r_rxv      <= 1'b0;
            r_rxd      <= 8'h00;
            r_rgb      <= 3'b010;
            r_err      <= 1'b0;
            r_rdy      <= 1'b0;
            r_cnt      <= '0;
            r_slot_v   <= BANNER_EN;
            r_slot_d   <= BANNER_EN ? BANNER_CHAR : 8'h00;
            r_last_usr <= 1'b1;
            r_gnt_usr  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_we       <= w_we;
            r_re       <= w_re;
            r_di       <= w_di;
            r_rxv      <= w_rxv;
            r_rxd      <= w_rxd;
            r_rgb      <= w_rgb;
            r_err      <= w_err;
            r_rdy      <= w_rdy;
            r_cnt      <= w_cnt;
            r_slot_v   <= w_slot_v;
            r_slot_d   <= w_slot_d;
            r_last_usr <= w_last_usr;
            r_gnt_usr  <= w_gnt_usr;
        end
    end

    assign uart_we      = r_we;
    assign uart_re      = r_re;
    assign uart_di      = {24'b0, r_di};
    assign usr_tx_ready = r_rdy;
    assign rx_valid     = r_rxv;
    assign rx_data      = r_rxd;
    assign rgb          = r_rgb;
    assign tx_err       = r_err;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: per-cycle vector table plus
// hand sequences for write timeout and reset during a write.
module tb_uart_link_ctrl;

    localparam int TO = 1000;
    localparam logic [31:0] E = 32'hFFFF_FFFF;

    logic        hw_clk = 1'b0;
    logic        resetn;
    logic        uart_we, uart_re;
    logic [31:0] uart_di, uart_do;
    logic        uart_wait;
    logic        usr_tx_valid;
    logic [7:0]  usr_tx_data;
    logic        usr_tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [2:0]  rgb;
    logic        tx_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_link_ctrl #(.TX_TIMEOUT(TO)) dut (
        .hw_clk       (hw_clk),
        .resetn       (resetn),
        .uart_we      (uart_we),
        .uart_re      (uart_re),
        .uart_di      (uart_di),
        .uart_do      (uart_do),
        .uart_wait    (uart_wait),
        .usr_tx_valid (usr_tx_valid),
        .usr_tx_data  (usr_tx_data),
        .usr_tx_ready (usr_tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rgb          (rgb),
        .tx_err       (tx_err)
    );

    always #5 hw_clk = ~hw_clk;

    typedef struct {
        logic        rn;
        logic [31:0] udo;
        logic        wt;
        logic        uv;
        logic [7:0]  ud;
        logic        we;
        logic        re;
        logic [7:0]  di;
        logic        rxv;
        logic [7:0]  rxd;
        logic [2:0]  rgb;
        logic        rdy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rn, input logic [31:0] udo, input logic wt,
        input logic uv, input logic [7:0] ud,
        input logic we, input logic re, input logic [7:0] di,
        input logic rxv, input logic [7:0] rxd,
        input logic [2:0] rg, input logic rdy);
        vec_t v;
        v.rn = rn; v.udo = udo; v.wt = wt; v.uv = uv; v.ud = ud;
        v.we = we; v.re = re; v.di = di; v.rxv = rxv;
        v.rxd = rxd; v.rgb = rg; v.rdy = rdy;
        return v;
    endfunction

    task automatic step();
        @(posedge hw_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [47:0] act, exp;
        int n_hi, n_rdy;

        resetn = 1'b0; uart_do = E; uart_wait = 1'b0;
        usr_tx_valid = 1'b0; usr_tx_data = 8'h00;

        // rn udo wt uv ud | we re di rxv rxd rgb rdy
        vq.push_back(mk(0, E,       0,0,8'h00, 0,0,8'h00,0,8'h00,3'b010,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 1,0,8'h50,0,8'h00,3'b010,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h50,0,8'h00,3'b010,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h50,0,8'h00,3'b010,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h50,0,8'h00,3'b010,0));
        vq.push_back(mk(1, 32'h35,  0,0,8'h00, 0,1,8'h50,1,8'h35,3'b101,0));
        vq.push_back(mk(1, 32'h35,  0,0,8'h00, 0,0,8'h50,0,8'h35,3'b101,0));
        vq.push_back(mk(1, 32'h35,  0,0,8'h00, 1,0,8'h4B,0,8'h35,3'b101,0));
        vq.push_back(mk(1, 32'h35,  0,0,8'h00, 0,0,8'h4B,0,8'h35,3'b101,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h4B,0,8'h35,3'b101,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h4B,0,8'h35,3'b101,0));
        vq.push_back(mk(1, 32'h41,  0,0,8'h00, 0,1,8'h4B,1,8'h41,3'b101,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h4B,0,8'h41,3'b101,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 1,0,8'h3F,0,8'h41,3'b101,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h3F,0,8'h41,3'b101,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h3F,0,8'h41,3'b101,0));
        vq.push_back(mk(1, E,       0,1,8'hA5, 1,0,8'hA5,0,8'h41,3'b101,0));
        vq.push_back(mk(1, E,       0,1,8'hA5, 0,0,8'hA5,0,8'h41,3'b101,1));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'hA5,0,8'h41,3'b101,0));
        vq.push_back(mk(1, 32'h37,  0,0,8'h00, 0,1,8'hA5,1,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,1,8'h55, 0,0,8'hA5,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,1,8'h55, 1,0,8'h4B,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       1,1,8'h55, 1,0,8'h4B,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,1,8'h55, 0,0,8'h4B,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,1,8'h55, 0,0,8'h4B,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,1,8'h55, 1,0,8'h55,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,1,8'h55, 0,0,8'h55,0,8'h37,3'b111,1));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h55,0,8'h37,3'b111,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h55,0,8'h37,3'b111,0));
        vq.push_back(mk(1, 32'h38,  0,0,8'h00, 0,1,8'h55,1,8'h38,3'b111,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h55,0,8'h38,3'b111,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 1,0,8'h3F,0,8'h38,3'b111,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h3F,0,8'h38,3'b111,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h3F,0,8'h38,3'b111,0));
        vq.push_back(mk(1, 32'h30,  0,0,8'h00, 0,1,8'h3F,1,8'h30,3'b000,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h3F,0,8'h30,3'b000,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 1,0,8'h4B,0,8'h30,3'b000,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h4B,0,8'h30,3'b000,0));
        vq.push_back(mk(1, E,       0,0,8'h00, 0,0,8'h4B,0,8'h30,3'b000,0));

        for (int i = 0; i < vq.size(); i++) begin
            resetn       = vq[i].rn;
            uart_do      = vq[i].udo;
            uart_wait    = vq[i].wt;
            usr_tx_valid = vq[i].uv;
            usr_tx_data  = vq[i].ud;
            step();
            act = {uart_we, uart_re, uart_di, rx_valid, rx_data,
                   rgb, usr_tx_ready, tx_err};
            exp = {vq[i].we, vq[i].re, 24'h0, vq[i].di, vq[i].rxv,
                   vq[i].rxd, vq[i].rgb, vq[i].rdy, 1'b0};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got we=%b re=%b di=%h rxv=%b rxd=%h rgb=%b rdy=%b err=%b, expected we=%b re=%b di=%h rxv=%b rxd=%h rgb=%b rdy=%b err=0",
                         i, uart_we, uart_re, uart_di, rx_valid, rx_data,
                         rgb, usr_tx_ready, tx_err, vq[i].we, vq[i].re,
                         {24'h0, vq[i].di}, vq[i].rxv, vq[i].rxd,
                         vq[i].rgb, vq[i].rdy);
            end
        end

        // user write stalled by uart_wait until the timeout fires
        usr_tx_valid = 1'b1; usr_tx_data = 8'hC3; uart_wait = 1'b1;
        step();
        chk("to_grant_we", {31'h0, uart_we}, 32'h1);
        chk("to_grant_di", uart_di, 32'hC3);
        n_hi = 1; n_rdy = 0;
        for (int i = 0; i < 2 * TO && uart_we; i++) begin
            step();
            if (usr_tx_ready) n_rdy++;
            if (uart_we) n_hi++;
        end
        chk("to_we_cycles", n_hi, TO);
        chk("to_we_low", {31'h0, uart_we}, 32'h0);
        chk("to_err_set", {31'h0, tx_err}, 32'h1);
        chk("to_rdy_pulse", {31'h0, usr_tx_ready}, 32'h1);
        usr_tx_valid = 1'b0;
        step();
        if (usr_tx_ready) n_rdy++;
        chk("to_rdy_once", n_rdy, 1);
        chk("to_err_sticky", {31'h0, tx_err}, 32'h1);
        uart_wait = 1'b0; usr_tx_valid = 1'b1; usr_tx_data = 8'h3C;
        step();
        chk("post_to_we", {31'h0, uart_we}, 32'h1);
        chk("post_to_di", uart_di, 32'h3C);
        step();
        chk("post_to_acc", {30'h0, uart_we, usr_tx_ready}, 32'h1);
        usr_tx_valid = 1'b0;
        step();
        chk("post_to_err", {31'h0, tx_err}, 32'h1);

        // reset asserted while a user write is stalled
        usr_tx_valid = 1'b1; usr_tx_data = 8'h99; uart_wait = 1'b1;
        step();
        chk("rst_wr_we", {31'h0, uart_we}, 32'h1);
        chk("rst_wr_di", uart_di, 32'h99);
        step();
        chk("rst_wr_hold", {31'h0, uart_we}, 32'h1);
        resetn = 1'b0;
        step();
        chk("rst_we_low", {31'h0, uart_we}, 32'h0);
        chk("rst_no_rdy", {31'h0, usr_tx_ready}, 32'h0);
        chk("rst_state", {24'h0, rgb, tx_err, uart_di[7:0] == 8'h0, 3'b0},
            {24'h0, 3'b010, 1'b0, 1'b1, 3'b0});
        resetn = 1'b1;
        step();
        chk("rst_banner_we", {30'h0, uart_we, usr_tx_ready}, 32'h2);
        chk("rst_banner_di", uart_di, 32'h50);
        uart_wait = 1'b0;
        step();
        chk("rst_banner_acc", {30'h0, uart_we, usr_tx_ready}, 32'h0);
        step();
        chk("rst_done", {30'h0, uart_we, usr_tx_ready}, 32'h0);
        step();
        chk("rst_usr_we", {31'h0, uart_we}, 32'h1);
        chk("rst_usr_di", uart_di, 32'h99);
        step();
        chk("rst_usr_rdy", {30'h0, uart_we, usr_tx_ready}, 32'h1);
        usr_tx_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
- Controller that owns the simpleuart register interface (dat_we/dat_re/dat_di/dat_do/dat_wait) and sequences all traffic through it.
- Drains received bytes and decodes single-character colour commands into an RGB state.
- Arbitrates the single TX channel round-robin between an internal response slot (banner/ACK/NAK) and one external user requester.
- Sits between simpleuart and the SB_RGBA_DRV PWM inputs in the top level.

Parameters:
BANNER_EN, 1, when 1 a BANNER_CHAR is queued in the response slot after reset
BANNER_CHAR, 8'h50 ("P"), startup character
ACK_CHAR, 8'h4B ("K"), response to a valid command
NAK_CHAR, 8'h3F ("?"), response to any other byte
TX_TIMEOUT, 1000, max cycles uart_we may stay high before the write is aborted

Ports:
hw_clk  in  1  system clock, 12 MHz
resetn  in  1  synchronous, active-low reset
uart_we  out  1  to simpleuart reg_dat_we
uart_re  out  1  to simpleuart reg_dat_re
uart_di  out  32  to simpleuart reg_dat_di, upper 24 bits always 0
uart_do  in  32  from reg_dat_do; 32'hFFFFFFFF = RX empty
uart_wait  in  1  from reg_dat_wait
usr_tx_valid  in  1  user byte pending; held until usr_tx_ready
usr_tx_data  in  8  user byte, stable while valid
usr_tx_ready  out  1  one-cycle pulse: user byte consumed (sent or dropped)
rx_valid  out  1  one-cycle pulse per received byte
rx_data  out  8  last received byte
rgb  out  3  {red, green, blue} PWM enables
tx_err  out  1  sticky: a write timed out

Behaviour:
- Reset (resetn=0 at a hw_clk edge): state IDLE; uart_we=0, uart_re=0, uart_di=0, usr_tx_ready=0, rx_valid=0, rx_data=0, tx_err=0.
- Reset also sets rgb=3'b010, timeout counter=0 and last_grant=user, so the response slot wins the first tie.
- Reset loads the response slot with BANNER_CHAR if BANNER_EN=1, otherwise the slot is empty.
- Reset asserted mid-operation (including WR) aborts immediately. uart_we is low in the cycle after the reset edge. No ready pulse is issued.
- States: IDLE, RD, WR, DONE.
- IDLE, RX branch (highest priority): taken when uart_do != 32'hFFFFFFFF and the response slot is empty.
  - Capture rx_data = uart_do[7:0].
  - Next cycle: state RD, uart_re=1, rx_valid=1.
  - Decode on capture: byte "0".."7" (8'h30..8'h37) sets rgb = byte[2:0] (bit2=red, bit1=green, bit0=blue) and loads the slot with ACK_CHAR. Any other byte leaves rgb unchanged and loads NAK_CHAR.
- RX backpressure: while the slot is occupied, RX is not read. The byte stays in simpleuart, which may drop later bytes; this is accepted.
- IDLE, TX branch (no RX branch taken): candidates are slot-occupied and usr_tx_valid.
  - Only one candidate: it is granted.
  - Both: grant the source not equal to last_grant.
  - On grant: uart_di = {24'b0, byte}, uart_we=1, last_grant updated, timeout counter cleared, state WR.
  - usr_tx_data is sampled only at grant.
- RD: lasts exactly one cycle; uart_re and rx_valid fall; back to IDLE. The byte is consumed exactly once.
- WR: uart_we held high.
  - Write accepted at the first edge where uart_we=1 and uart_wait=0.
  - Next cycle: state DONE, uart_we=0. The granted source is cleared (slot emptied, or usr_tx_ready pulsed).
  - Counter increments each WR cycle. If it reaches TX_TIMEOUT with no acceptance: uart_we=0, tx_err=1, byte dropped, source cleared the same way, state DONE.
- DONE: one idle cycle (uart_we low for at least one cycle between bytes), then IDLE.
- No RX read starts during WR/DONE. A byte arriving then is handled in the next IDLE.
- The RX branch and the TX branch never both fire in the same IDLE cycle.
- Latency:
  - IDLE-sampled RX byte to uart_re high: 1 cycle.
  - Slot write to uart_we high: at most 3 cycles if no contention.

Test Plan:
- Reset with BANNER_EN=1, uart_wait=0, uart_do=all ones -> one write with uart_di=32'h50; rgb=3'b010; uart_we high exactly 1 cycle, then low for at least 1 cycle; no uart_re.
- uart_do=32'h35 ("5") -> uart_re and rx_valid pulse once, rx_data=8'h35, rgb=3'b101, then one write of 8'h4B; uart_do restored to all ones afterwards with no second read.
- uart_do=32'h41 ("A") with rgb=3'b101 -> rgb unchanged, write of 8'h3F.
- Slot holds "K" and usr_tx_valid=1 with data 8'h55 simultaneously after a user grant -> "K" granted first, then 8'h55; usr_tx_ready pulses once after the second acceptance.
- uart_wait held 1 during a user write -> uart_we drops after exactly TX_TIMEOUT cycles; tx_err=1 and stays 1; usr_tx_ready pulses once; the next write proceeds normally.
- resetn pulsed low during WR -> uart_we=0 in the next cycle, no usr_tx_ready pulse, banner re-queued.
